regfile_dump_reader: RTL and testbench
======================================

# regfile_dump_reader

Debug readout engine that walks a range of the register file through its debug read port and streams each 32-bit register out as bytes over a valid/ready byte interface (toward the board UART/debug link). It sits beside the CPU datapath, owns the register file's debug address input, and has its debug clock tied to `clock`. The CPU core is not stalled; values are sampled as they are at read time.

## Interface
Parameters:
- `READ_LATENCY`, 2, number of `clock` edges after `rf_addr` changes before `rf_data` is valid to sample; legal range 1–7.

Ports:
- `clock`  in  1  single system clock; the register file's debug clock is driven from it.
- `reset_n`  in  1  reset, asynchronous, active-low.
- `start`  in  1  one-cycle request to begin a dump; ignored while `busy`.
- `first_addr`  in  5  first register index; sampled on the accepted `start` edge.
- `last_addr`  in  5  last register index, inclusive; sampled on the accepted `start` edge.
- `rf_addr`  out  5  drives the register file's debug read address.
- `rf_data`  in  32  the register file's debug read data.
- `byte_data`  out  8  outgoing byte.
- `byte_valid`  out  1  `byte_data` is valid.
- `byte_ready`  in  1  sink accepts the byte.
- `busy`  out  1  dump in progress.
- `done`  out  1  one-cycle pulse after the final byte is accepted.

## Operation
- States: IDLE, WAIT, SEND.
- IDLE, `start`=1: latch `first_addr`/`last_addr`; set `cur` and `rf_addr` to `first_addr`, wait counter to `READ_LATENCY`, `busy`=1, go to WAIT.
- WAIT: decrement the counter each edge. On the edge where the counter equals 1:
  - capture `rf_data` into the shift word;
  - load the first byte and set `byte_valid`=1;
  - go to SEND.
- SEND:
  - A byte transfers on an edge with `byte_valid`=1 and `byte_ready`=1.
  - `byte_data` is stable while it is valid and not yet accepted.
  - Bytes go out MSB first, `[31:24]` … `[7:0]`.
  - After the last byte of a word transfers:
    - if `cur`≠`last`: `cur`/`rf_addr` ← `cur`+1 (mod 32), `byte_valid`=0, counter reloaded, go to WAIT;
    - else: `byte_valid`=0, `busy`=0, `done`=1 for one cycle, go to IDLE.
- Word count = ((`last`−`first`) mod 32) + 1. Examples:
  - `first`=`last` → 1 word.
  - `first`=0, `last`=31 → 32 words.
  - `first`=30, `last`=1 → 4 words, wrapping 30, 31, 0, 1.
- `start` while `busy`: ignored; the latched range is unchanged.
- `start` on the same edge that `done` is asserted: ignored, because the block is still `busy` on that edge.
- `byte_ready` held low: the block stalls indefinitely in SEND. No timeout.

## Timing
- Reset values: `rf_addr`=0, `byte_data`=0, `byte_valid`=0, `busy`=0, `done`=0, state IDLE.
- Reset asserted mid-dump: outputs clear immediately (asynchronously); the partial stream is abandoned and no `done` is issued.
- First `byte_valid` is asserted `READ_LATENCY` edges after the accepted `start` edge.
- With `byte_ready` held high:
  - each word takes `READ_LATENCY`+4 cycles (`READ_LATENCY`+5 with header);
  - full default dump without header = 32×6 = 192 cycles.
- All outputs are registered. No combinational path from `byte_ready` to any output.

## Configuration
- `REGFILE_DUMP_HEADER_EN` defined: each word is preceded by a header byte `{3'b101, cur}`, sent first in the same SEND phase (5 bytes per word).
- `REGFILE_DUMP_HEADER_EN` undefined: 4 bytes per word, no header logic is synthesized, and the byte counter is 2 bits.

## Structure
- Package `regfile_dump_pkg` holds:
  - the state enum `dump_state_t`;
  - `DUMP_HDR_TAG` = 3'b101;
  - `DUMP_BYTES_PER_WORD`, 4 or 5 depending on the macro.
- Single module; no sub-module. The byte shifter is a small inline register plus counter.

## Test plan
- Register file at reset (r1=0xFFFFFFE2, r2=0x38); dump `first`=1, `last`=2; `byte_ready`=1 → bytes FF FF FF E2 00 00 00 38, then `done` pulse; `busy` low on the following cycle.
- Same dump with `REGFILE_DUMP_HEADER_EN` → bytes A1 FF FF FF E2 A2 00 00 00 38.
- Toggle `byte_ready` low for 3 cycles mid-word → `byte_data` held constant while stalled; no byte dropped or duplicated.
- Wrap dump with `first`=31, `last`=0 → `rf_addr` sequence 31 then 0; exactly 8 bytes; r0 bytes are all 00.
- Pulse `start` again while `busy` with a different range → ignored; output identical to the unperturbed run.
- Assert `reset_n`=0 during the third byte → `byte_valid`, `busy` and `rf_addr` go to 0 asynchronously; a new `start` after release dumps correctly.

Source files
------------

// File: rtl/regfile_dump_pkg.sv
// Shared types and constants for the register-file dump reader.
// REGFILE_DUMP_HEADER_EN selects the 5-byte-per-word format with a leading header byte.
package regfile_dump_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_SEND = 2'd2
    } dump_state_t;

    localparam logic [2:0] DUMP_HDR_TAG = 3'b101;

`ifdef REGFILE_DUMP_HEADER_EN
    localparam int DUMP_BYTES_PER_WORD = 5;
    localparam int DUMP_BCNT_W         = 3;
`else
    localparam int DUMP_BYTES_PER_WORD = 4;
    localparam int DUMP_BCNT_W         = 2;
`endif

endpackage

// File: rtl/regfile_dump_reader.sv
// Walks a register-file range over the debug read port and streams each word as bytes, MSB first.
// Build option: REGFILE_DUMP_HEADER_EN prefixes each word with a {3'b101, index} header byte.
module regfile_dump_reader
    import regfile_dump_pkg::*;
#(
    parameter int READ_LATENCY = 2
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    input  logic [4:0]  first_addr,
    input  logic [4:0]  last_addr,
    output logic [4:0]  rf_addr,
    input  logic [31:0] rf_data,
    output logic [7:0]  byte_data,
    output logic        byte_valid,
    input  logic        byte_ready,
    output logic        busy,
    output logic        done
);

    localparam logic [2:0]             LAT_LOAD  = 3'(READ_LATENCY);
    localparam logic [DUMP_BCNT_W-1:0] LAST_BYTE = DUMP_BCNT_W'(DUMP_BYTES_PER_WORD - 1);

    dump_state_t             state_q, state_d;
    logic [4:0]              cur_q, cur_d;
    logic [4:0]              last_q, last_d;
    logic [2:0]              wcnt_q, wcnt_d;
    logic [DUMP_BCNT_W-1:0]  bcnt_q, bcnt_d;
    logic [31:0]             shift_q, shift_d;
    logic [7:0]              byte_q, byte_d;
    logic                    valid_q, valid_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cur_q   <= 5'd0;
            last_q  <= 5'd0;
            wcnt_q  <= 3'd0;
            bcnt_q  <= '0;
            shift_q <= 32'd0;
            byte_q  <= 8'd0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            last_q  <= last_d;
            wcnt_q  <= wcnt_d;
            bcnt_q  <= bcnt_d;
            shift_q <= shift_d;
            byte_q  <= byte_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        last_d  = last_q;
        wcnt_d  = wcnt_q;
        bcnt_d  = bcnt_q;
        shift_d = shift_q;
        byte_d  = byte_q;
        valid_d = valid_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    last_d  = last_addr;
                    cur_d   = first_addr;
                    wcnt_d  = LAT_LOAD;
                    busy_d  = 1'b1;
                    state_d = ST_WAIT;
                end
            end

            ST_WAIT: begin
                wcnt_d = wcnt_q - 3'd1;
                // rf_data has settled for the address held in cur_q on this edge
                if (wcnt_q == 3'd1) begin
                    bcnt_d  = '0;
                    valid_d = 1'b1;
                    state_d = ST_SEND;
`ifdef REGFILE_DUMP_HEADER_EN
                    byte_d  = {DUMP_HDR_TAG, cur_q};
                    shift_d = rf_data;
`else
                    byte_d  = rf_data[31:24];
                    shift_d = {rf_data[23:0], 8'h00};
`endif
                end
            end

            ST_SEND: begin
                if (valid_q && byte_ready) begin
                    if (bcnt_q == LAST_BYTE) begin
                        valid_d = 1'b0;
                        if (cur_q != last_q) begin
                            cur_d   = cur_q + 5'd1;
                            wcnt_d  = LAT_LOAD;
                            state_d = ST_WAIT;
                        end else begin
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                            state_d = ST_IDLE;
                        end
                    end else begin
                        bcnt_d  = bcnt_q + 1'b1;
                        byte_d  = shift_q[31:24];
                        shift_d = {shift_q[23:0], 8'h00};
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign rf_addr    = cur_q;
    assign byte_data  = byte_q;
    assign byte_valid = valid_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Randomized bench for regfile_dump_reader against a queue-based model of the byte stream.
// Honours REGFILE_DUMP_HEADER_EN to expect header bytes.
module tb_regfile_dump_reader;

    localparam int RL   = 2;
    localparam int PIDX = (RL >= 2) ? RL - 2 : 0;
`ifdef REGFILE_DUMP_HEADER_EN
    localparam int HDR = 1;
`else
    localparam int HDR = 0;
`endif

    logic        clock = 1'b0;
    logic        reset_n = 1'b1;
    logic        start = 1'b0;
    logic [4:0]  first_addr = 5'd0;
    logic [4:0]  last_addr = 5'd0;
    logic [4:0]  rf_addr;
    logic [31:0] rf_data;
    logic [7:0]  byte_data;
    logic        byte_valid;
    logic        byte_ready = 1'b1;
    logic        busy;
    logic        done;

    regfile_dump_reader #(.READ_LATENCY(RL)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .start      (start),
        .first_addr (first_addr),
        .last_addr  (last_addr),
        .rf_addr    (rf_addr),
        .rf_data    (rf_data),
        .byte_data  (byte_data),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .busy       (busy),
        .done       (done)
    );

    always #5 clock = ~clock;

    // Register file model with a registered read path of RL edges
    logic [31:0] regs [32];
    logic [31:0] pipe [7];
    always @(posedge clock) begin
        pipe[0] <= regs[rf_addr];
        for (int i = 1; i < 7; i++) pipe[i] <= pipe[i-1];
    end
    assign rf_data = (RL == 1) ? regs[rf_addr] : pipe[PIDX];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Monitor: collects transferred bytes and word addresses, checks hold stability
    logic [7:0] got_q [$];
    logic [4:0] addr_q [$];
    int         done_cnt = 0;
    logic       prev_hold = 1'b0;
    logic       prev_valid = 1'b0;
    logic [7:0] prev_byte = 8'h00;

    always @(negedge clock) begin
        if (!reset_n) begin
            prev_hold  = 1'b0;
            prev_valid = 1'b0;
        end else begin
            if (prev_hold) begin
                chk("hold_vld", {31'd0, byte_valid}, 32'd1);
                chk("hold_data", {24'd0, byte_data}, {24'd0, prev_byte});
            end
            if (byte_valid && !prev_valid) addr_q.push_back(rf_addr);
            if (byte_valid && byte_ready) got_q.push_back(byte_data);
            if (done) done_cnt++;
            prev_hold  = byte_valid && !byte_ready;
            prev_byte  = byte_data;
            prev_valid = byte_valid;
        end
    end

    // Sink: 0 always ready, 1 random, 2 held low, 3 ready except a 3-cycle stall on the third byte
    int ready_mode = 0;
    int stall_cnt  = 0;
    initial begin
        forever begin
            @(posedge clock);
            #1;
            case (ready_mode)
                0: byte_ready = 1'b1;
                1: byte_ready = ($urandom_range(0, 3) != 0);
                3: begin
                    if (got_q.size() == 2 && stall_cnt < 3) begin
                        byte_ready = 1'b0;
                        stall_cnt++;
                    end else begin
                        byte_ready = 1'b1;
                    end
                end
                default: byte_ready = 1'b0;
            endcase
        end
    end

    function automatic int word_count(input logic [4:0] f, input logic [4:0] l);
        return (((int'(l) - int'(f)) % 32 + 32) % 32) + 1;
    endfunction

    task automatic run_dump(input logic [4:0] f, input logic [4:0] l, input int mode,
                            input bit perturb, input string tag);
        logic [7:0] exp_b [$];
        logic [4:0] exp_a [$];
        logic [4:0] a;
        int n;
        int lat;
        int cyc;
        n = word_count(f, l);
        for (int w = 0; w < n; w++) begin
            a = 5'((int'(f) + w) % 32);
            exp_a.push_back(a);
            if (HDR != 0) exp_b.push_back({3'b101, a});
            for (int b = 3; b >= 0; b--) exp_b.push_back(regs[a][8*b +: 8]);
        end
        got_q.delete();
        addr_q.delete();
        done_cnt   = 0;
        stall_cnt  = 0;
        ready_mode = mode;

        first_addr = f;
        last_addr  = l;
        start      = 1'b1;
        @(posedge clock);
        #1;
        start      = 1'b0;
        first_addr = 5'($urandom);
        last_addr  = 5'($urandom);

        lat = 0;
        while (!byte_valid && lat < 20) begin
            @(posedge clock);
            #1;
            lat++;
        end
        chk({tag, "_latency"}, lat, RL);

        cyc = lat;
        while (!done && cyc < 4000) begin
            if (perturb && cyc == lat + 3) begin
                first_addr = f + 5'd5;
                last_addr  = l + 5'd9;
                start      = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(posedge clock);
            #1;
            cyc++;
        end
        start = 1'b0;
        chk({tag, "_done_seen"}, {31'd0, done}, 32'd1);
        chk({tag, "_busy_at_done"}, {31'd0, busy}, 32'd0);
        if (mode == 0) chk({tag, "_cycles"}, cyc, n * (RL + 4 + HDR));

        @(posedge clock);
        #1;
        chk({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
        chk({tag, "_busy_after"}, {31'd0, busy}, 32'd0);
        @(negedge clock);
        #1;

        chk({tag, "_nbytes"}, got_q.size(), exp_b.size());
        for (int i = 0; i < exp_b.size() && i < got_q.size(); i++)
            chk({tag, "_byte"}, {24'd0, got_q[i]}, {24'd0, exp_b[i]});
        chk({tag, "_nwords"}, addr_q.size(), exp_a.size());
        for (int i = 0; i < exp_a.size() && i < addr_q.size(); i++)
            chk({tag, "_addr"}, {27'd0, addr_q[i]}, {27'd0, exp_a[i]});
        chk({tag, "_done_count"}, done_cnt, 1);
        ready_mode = 0;
    endtask

    initial begin
        int cyc;
        for (int i = 0; i < 32; i++) regs[i] = $urandom;
        regs[0] = 32'h0000_0000;
        regs[1] = 32'hFFFF_FFE2;
        regs[2] = 32'h0000_0038;

        #2 reset_n = 1'b0;
        #1;
        chk("rst_rf_addr", {27'd0, rf_addr}, 32'd0);
        chk("rst_byte_data", {24'd0, byte_data}, 32'd0);
        chk("rst_byte_valid", {31'd0, byte_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        repeat (3) @(posedge clock);
        #1 reset_n = 1'b1;
        repeat (2) @(posedge clock);
        #1;

        run_dump(5'd1,  5'd2,  0, 1'b0, "basic");
        run_dump(5'd1,  5'd2,  3, 1'b0, "stall");
        run_dump(5'd31, 5'd0,  0, 1'b0, "wrap");
        run_dump(5'd30, 5'd1,  1, 1'b0, "wrap4");
        run_dump(5'd3,  5'd6,  0, 1'b1, "perturb");
        run_dump(5'd9,  5'd9,  0, 1'b0, "single");
        run_dump(5'd0,  5'd31, 0, 1'b0, "full");

        // Reset asserted while the third byte is on the link
        got_q.delete();
        done_cnt   = 0;
        ready_mode = 0;
        first_addr = 5'd1;
        last_addr  = 5'd2;
        start      = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        cyc = 0;
        while (got_q.size() < 2 && cyc < 50) begin
            @(posedge clock);
            #1;
            cyc++;
        end
        #2;
        chk("rst_mid_pre_vld", {31'd0, byte_valid}, 32'd1);
        reset_n = 1'b0;
        #1;
        chk("rst_mid_vld", {31'd0, byte_valid}, 32'd0);
        chk("rst_mid_busy", {31'd0, busy}, 32'd0);
        chk("rst_mid_addr", {27'd0, rf_addr}, 32'd0);
        repeat (2) @(posedge clock);
        #1 reset_n = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        chk("rst_mid_no_done", done_cnt, 0);
        run_dump(5'd1, 5'd2, 0, 1'b0, "post_rst");

        for (int k = 0; k < 6; k++) begin
            for (int i = 3; i < 32; i++) regs[i] = $urandom;
            run_dump(5'($urandom), 5'($urandom), int'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)), "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
